fp_normalize_pack: RTL and testbench



---
 rtl/fp_normalize_pack_if.sv | 24 ++
 rtl/fp_normalize_pack.sv | 144 ++++++++++++++
 tb/tb_fp_normalize_pack.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fp_normalize_pack_if.sv
// Handshake bundle between the FP adder core and fp_normalize_pack.
// The slave modport is the normalizer side; master is the producer/consumer side.
interface fp_normalize_pack_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [27:0] in_mant;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic        out_ovf;
   logic        out_unf;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, out_res, out_ovf, out_unf
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, out_ready,
      output in_ready, out_valid, out_res, out_ovf, out_unf
   );
endinterface

// File: rtl/fp_normalize_pack.sv
// FP adder back end: normalize raw sum, round to nearest-even, pack binary32.
// Optional macro FPU_NORM_FASTSHIFT_EN replaces the 1-bit/cycle shifter with a one-cycle LZC barrel shift.
module fp_normalize_pack (
   input  logic                    clk,
   input  logic                    rst_n,
   fp_normalize_pack_if.slave      bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

   state_t      state, state_nx;
   logic        sgn, sgn_nx;
   logic [8:0]  e, e_nx;
   logic [27:0] m, m_nx;
   logic [31:0] res, res_nx;
   logic        ovf, ovf_nx;
   logic        unf, unf_nx;

   logic        inexact;
   logic        inc;
   logic [24:0] rsum;
   logic [8:0]  e_rnd;
   logic        hid;
   logic [22:0] frac;
   logic [7:0]  field;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sgn   <= 1'b0;
         e     <= '0;
         m     <= '0;
         res   <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         state <= state_nx;
         sgn   <= sgn_nx;
         e     <= e_nx;
         m     <= m_nx;
         res   <= res_nx;
         ovf   <= ovf_nx;
         unf   <= unf_nx;
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_res   = res;
   assign bus.out_ovf   = ovf;
   assign bus.out_unf   = unf;

   // Rounding datapath; a carry out of the 24-bit significand bumps the exponent.
   always_comb begin
      inexact = |m[2:0];
      inc     = m[2] & (m[1] | m[0] | m[3]);
      rsum    = {1'b0, m[26:3]} + {24'd0, inc};
      if (rsum[24]) begin
         e_rnd = e + 9'd1;
         hid   = 1'b1;
         frac  = '0;
      end else begin
         e_rnd = e;
         hid   = rsum[23];
         frac  = rsum[22:0];
      end
      field = hid ? e_rnd[7:0] : 8'd0;
   end

`ifdef FPU_NORM_FASTSHIFT_EN
   logic [4:0] lzc;
   logic [8:0] amt;

   // Shift is clamped at e-1 so a denormal stops at exponent 1, as the iterative loop does.
   always_comb begin
      lzc = 5'd27;
      for (int unsigned i = 0; i < 27; i++) begin
         if (m[i]) lzc = 5'(26 - i);
      end
      amt = ({4'd0, lzc} < (e - 9'd1)) ? {4'd0, lzc} : (e - 9'd1);
   end
`endif

   always_comb begin
      state_nx = state;
      sgn_nx   = sgn;
      e_nx     = e;
      m_nx     = m;
      res_nx   = res;
      ovf_nx   = ovf;
      unf_nx   = unf;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               sgn_nx   = bus.in_sign;
               e_nx     = {1'b0, (bus.in_exp == 8'd0) ? 8'd1 : bus.in_exp};
               m_nx     = bus.in_mant;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (m == '0) begin
               sgn_nx   = 1'b0;
               res_nx   = '0;
               ovf_nx   = 1'b0;
               unf_nx   = 1'b0;
               state_nx = DONE;
            end else if (m[27]) begin
               m_nx     = {1'b0, m[27:2], m[1] | m[0]};
               e_nx     = e + 9'd1;
               state_nx = ROUND;
            end else if (m[26] || (e == 9'd1)) begin
               state_nx = ROUND;
            end else begin
`ifdef FPU_NORM_FASTSHIFT_EN
               m_nx     = m << amt;
               e_nx     = e - amt;
               state_nx = ROUND;
`else
               m_nx     = {m[26:0], 1'b0};
               e_nx     = e - 9'd1;
`endif
            end
         end
         ROUND: begin
            if (e_rnd >= 9'd255) begin
               res_nx = {sgn, 8'hFF, 23'h0};
               ovf_nx = 1'b1;
               unf_nx = 1'b0;
            end else begin
               res_nx = {sgn, field, frac};
               ovf_nx = 1'b0;
               unf_nx = (field == 8'd0) & inexact;
            end
            state_nx = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed, table-driven bench for fp_normalize_pack (both shifter builds).
module tb_fp_normalize_pack;

`ifdef FPU_NORM_FASTSHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [27:0] mant;
      logic [7:0]  k;
      logic        zero;
      logic [31:0] res;
      logic        ovf;
      logic        unf;
   } vec_t;

   logic clk;
   logic rst_n;
   fp_normalize_pack_if bus();

   fp_normalize_pack dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   vec_t vecs [18];
   int   total  = 0;
   int   passed = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic run(input int idx, input int hold);
      vec_t v;
      int   lat_exp;
      int   cyc;
      bit   got;
      v = vecs[idx];
      lat_exp = v.zero ? 2 : (FAST ? 3 : int'(v.k) + 3);
      @(negedge clk);
      check($sformatf("v%0d_in_ready", idx), {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_sign  = v.sign;
      bus.in_exp   = v.exp;
      bus.in_mant  = v.mant;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      got = 1'b0;
      cyc = 999;
      for (int c = 1; c <= 80 && !got; c++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = 1'b1;
            cyc = c;
         end
      end
      check($sformatf("v%0d_latency", idx), cyc, lat_exp);
      if (!got) return;
      check($sformatf("v%0d_res", idx), bus.out_res, v.res);
      check($sformatf("v%0d_ovf", idx), {31'd0, bus.out_ovf}, {31'd0, v.ovf});
      check($sformatf("v%0d_unf", idx), {31'd0, bus.out_unf}, {31'd0, v.unf});
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = 1'b1;
         bus.in_exp   = 8'd100;
         bus.in_mant  = 28'h4000000 | 28'($urandom_range(0, 255));
         @(negedge clk);
         check($sformatf("v%0d_hold%0d_valid", idx, h), {31'd0, bus.out_valid}, 32'd1);
         check($sformatf("v%0d_hold%0d_in_ready", idx, h), {31'd0, bus.in_ready}, 32'd0);
         check($sformatf("v%0d_hold%0d_res", idx, h), bus.out_res, v.res);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   initial begin
      bit seen;
      //          sign exp     mant          k      zero  res           ovf   unf
      vecs[0]  = '{1'b0, 8'd127, 28'h8000000, 8'd0,  1'b0, 32'h40000000, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 8'd127, 28'h0000008, 8'd23, 1'b0, 32'h34000000, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 8'd127, 28'h4000004, 8'd0,  1'b0, 32'h3F800000, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 8'd127, 28'h400000C, 8'd0,  1'b0, 32'h3F800002, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 8'd254, 28'h8000000, 8'd0,  1'b0, 32'h7F800000, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 8'd254, 28'h8000000, 8'd0,  1'b0, 32'hFF800000, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 8'd1,   28'h2000000, 8'd0,  1'b0, 32'h00400000, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 8'd1,   28'h2000001, 8'd0,  1'b0, 32'h00400000, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 8'd127, 28'h0000000, 8'd0,  1'b1, 32'h00000000, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 8'd0,   28'h2000000, 8'd0,  1'b0, 32'h00400000, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 8'd1,   28'h3FFFFFC, 8'd0,  1'b0, 32'h00800000, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 8'd127, 28'h7FFFFFC, 8'd0,  1'b0, 32'h40000000, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 8'd254, 28'h7FFFFFC, 8'd0,  1'b0, 32'h7F800000, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 8'd3,   28'h0800000, 8'd2,  1'b0, 32'h00400000, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 8'd130, 28'h4000000, 8'd0,  1'b0, 32'hC1000000, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 8'd127, 28'h4000006, 8'd0,  1'b0, 32'h3F800001, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 8'd2,   28'h1000001, 8'd1,  1'b0, 32'h00400000, 1'b0, 1'b1};
      vecs[17] = '{1'b0, 8'd1,   28'h0000004, 8'd0,  1'b0, 32'h00000000, 1'b0, 1'b1};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_exp    = '0;
      bus.in_mant   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_res",   bus.out_res,            32'd0);
      check("rst_out_ovf",   {31'd0, bus.out_ovf},   32'd0);
      check("rst_out_unf",   {31'd0, bus.out_unf},   32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) run(i, 0);

      // Backpressure: zero result then a nonzero one, with junk offered on the input side.
      run(8, 5);
      run(0, 3);

      // Reset in the middle of a long cancellation shift.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sign  = vecs[1].sign;
      bus.in_exp   = vecs[1].exp;
      bus.in_mant  = vecs[1].mant;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_pre_valid",    {31'd0, bus.out_valid}, 32'd0);
      check("abort_pre_in_ready", {31'd0, bus.in_ready},  32'd0);
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", {31'd0, bus.in_ready},  32'd1);
      check("abort_valid",    {31'd0, bus.out_valid}, 32'd0);
      check("abort_res",      bus.out_res,            32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      check("abort_no_result", {31'd0, seen},         32'd0);
      check("abort_idle",      {31'd0, bus.in_ready}, 32'd1);

      run(3, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
